// File: rtl/i2c_eeprom_slave_core_if.sv
// Signal bundle between the I2C pad buffers / EEPROM storage array and the
// slave byte engine. The engine uses the slave modport, its environment the master one.
interface i2c_eeprom_slave_core_if #(
    parameter int ADDR_W = 8
);
    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata;
    logic              busy;

    modport slave (
        input  scl_in, sda_in, mem_rdata,
        output sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
    );

    modport master (
        output scl_in, sda_in, mem_rdata,
        input  sda_oe, mem_addr, mem_wdata, mem_we, mem_re, busy
    );
endinterface

// File: rtl/i2c_eeprom_slave_core.sv
// I2C EEPROM slave byte engine: oversampled START/STOP/bit decode, device match,
// word-pointer load, page-wrapped writes and auto-incrementing sequential reads.
module i2c_eeprom_slave_core #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         ADDR_W   = 8,
    parameter int         PAGE_W   = 3
) (
    input logic                    clk,
    input logic                    rst_n,
    i2c_eeprom_slave_core_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, DEV, ADDR_HI, ADDR_LO, WRITE, READ, RD_ACK, WAIT
    } state_t;

    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((1 << PAGE_W) - 1);

    logic scl_s1, scl_s2, scl_h;
    logic sda_s1, sda_s2, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t            state, state_n;
    logic [ADDR_W-1:0] ptr, ptr_n;
    logic [7:0]        shift, shift_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic              byte_done, byte_done_n;
    logic              in_ack, in_ack_n;
    logic              fetch, fetch_n;
    logic              load, load_n;
    logic [6:0]        tx, tx_n;
    logic              oe_q, oe_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [7:0]        wdata_q, wdata_n;
    logic              we_q, we_n;
    logic              re_q, re_n;
    logic              busy_q, busy_n;
    logic [15:0]       ext;

    // Synchronizers idle high so reset release on an idle bus produces no edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_in;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= bus.sda_in;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 & scl_h;
    assign start_det = scl_s2 & scl_h & sda_h & ~sda_s2;
    assign stop_det  = scl_s2 & scl_h & ~sda_h & sda_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            shift     <= '0;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            in_ack    <= 1'b0;
            fetch     <= 1'b0;
            load      <= 1'b0;
            tx        <= '0;
            oe_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            shift     <= shift_n;
            bit_cnt   <= bit_cnt_n;
            byte_done <= byte_done_n;
            in_ack    <= in_ack_n;
            fetch     <= fetch_n;
            load      <= load_n;
            tx        <= tx_n;
            oe_q      <= oe_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            we_q      <= we_n;
            re_q      <= re_n;
            busy_q    <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        shift_n     = shift;
        bit_cnt_n   = bit_cnt;
        byte_done_n = byte_done;
        in_ack_n    = in_ack;
        fetch_n     = fetch;
        load_n      = 1'b0;
        tx_n        = tx;
        oe_n        = oe_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        we_n        = 1'b0;
        re_n        = 1'b0;
        busy_n      = busy_q;
        ext         = 16'(ptr);

        if (start_det) begin
            state_n     = DEV;
            bit_cnt_n   = '0;
            byte_done_n = 1'b0;
            in_ack_n    = 1'b0;
            fetch_n     = 1'b0;
            oe_n        = 1'b0;
        end else if (stop_det) begin
            state_n     = IDLE;
            bit_cnt_n   = '0;
            byte_done_n = 1'b0;
            in_ack_n    = 1'b0;
            fetch_n     = 1'b0;
            oe_n        = 1'b0;
            busy_n      = 1'b0;
        end else begin
            case (state)
                DEV, ADDR_HI, ADDR_LO, WRITE: begin
                    // The master's 9th clock of a byte belongs to our ACK and is not data
                    if (scl_rise && !in_ack) begin
                        shift_n   = {shift[6:0], sda_s2};
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done_n = 1'b1;
                    end else if (scl_fall && in_ack) begin
                        in_ack_n = 1'b0;
                        oe_n     = 1'b0;
                    end else if (scl_fall && byte_done) begin
                        byte_done_n = 1'b0;
                        in_ack_n    = 1'b1;
                        oe_n        = 1'b1;
                        case (state)
                            DEV: begin
                                if (shift[7:1] == DEV_ADDR) begin
                                    busy_n = 1'b1;
                                    if (shift[0]) begin
                                        state_n = READ;
                                        fetch_n = 1'b1;
                                    end else begin
                                        state_n = (ADDR_W > 8) ? ADDR_HI : ADDR_LO;
                                    end
                                end else begin
                                    state_n  = WAIT;
                                    in_ack_n = 1'b0;
                                    oe_n     = 1'b0;
                                end
                            end
                            ADDR_HI: begin
                                ptr_n   = ADDR_W'({shift, ext[7:0]});
                                state_n = ADDR_LO;
                            end
                            ADDR_LO: begin
                                ptr_n   = ADDR_W'({ext[15:8], shift});
                                state_n = WRITE;
                            end
                            default: begin
                                we_n    = 1'b1;
                                addr_n  = ptr;
                                wdata_n = shift;
                                ptr_n   = (ptr & ~PAGE_MASK) | ((ptr + ADDR_W'(1)) & PAGE_MASK);
                            end
                        endcase
                    end
                end
                READ: begin
                    // Fetch on the fall closing the ACK slot; data arrives two clocks later
                    if (re_q) load_n = 1'b1;
                    if (load) begin
                        tx_n      = bus.mem_rdata[6:0];
                        oe_n      = ~bus.mem_rdata[7];
                        bit_cnt_n = '0;
                    end else if (scl_fall) begin
                        if (fetch) begin
                            fetch_n  = 1'b0;
                            in_ack_n = 1'b0;
                            oe_n     = 1'b0;
                            re_n     = 1'b1;
                            addr_n   = ptr;
                        end else if (!re_q) begin
                            if (bit_cnt == 3'd7) begin
                                oe_n    = 1'b0;
                                state_n = RD_ACK;
                            end else begin
                                tx_n      = {tx[5:0], 1'b0};
                                oe_n      = ~tx[6];
                                bit_cnt_n = bit_cnt + 3'd1;
                            end
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s2) begin
                            ptr_n   = ptr + ADDR_W'(1);
                            state_n = READ;
                            fetch_n = 1'b1;
                        end else begin
                            state_n = WAIT;
                            oe_n    = 1'b0;
                        end
                    end
                end
                WAIT: oe_n = 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.sda_oe    = oe_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_re    = re_q;
    assign bus.busy      = busy_q;

endmodule
